// File: rtl/hub75_fb_writer_pkg.sv
// Shared definitions for the HUB75 frame-buffer write sequencer: FSM state encoding and
// default geometry (pixel width = N_CHANS * N_PLANES).
package hub75_fb_writer_pkg;

    typedef enum logic [2:0] {
        ST_FILL     = 3'd0,
        ST_WAIT_ROW = 3'd1,
        ST_STORE    = 3'd2,
        ST_WAIT_FRM = 3'd3,
        ST_SWAP     = 3'd4
    } state_t;

    localparam int DEF_N_BANKS  = 2;
    localparam int DEF_N_ROWS   = 32;
    localparam int DEF_N_COLS   = 64;
    localparam int DEF_N_CHANS  = 3;
    localparam int DEF_N_PLANES = 8;
    localparam int DEF_PIXEL_W  = DEF_N_CHANS * DEF_N_PLANES;

endpackage

// File: rtl/hub75_fb_writer_addr_cnt.sv
// Cascaded col -> row -> bank raster counter; all dimensions must be powers of two so
// that every level wraps by natural overflow.
module hub75_fb_writer_addr_cnt
    import hub75_fb_writer_pkg::*;
#(
    parameter int N_BANKS     = DEF_N_BANKS,
    parameter int N_ROWS      = DEF_N_ROWS,
    parameter int N_COLS      = DEF_N_COLS,
    parameter int LOG_N_BANKS = $clog2(N_BANKS),
    parameter int LOG_N_ROWS  = $clog2(N_ROWS),
    parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_col_inc,
    input  logic                   i_row_inc,
    output logic [LOG_N_COLS-1:0]  o_col,
    output logic [LOG_N_ROWS-1:0]  o_row,
    output logic [LOG_N_BANKS-1:0] o_bank,
    output logic                   o_col_last,
    output logic                   o_frame_last
);

    logic [LOG_N_COLS-1:0]  r_col;
    logic [LOG_N_ROWS-1:0]  r_row;
    logic [LOG_N_BANKS-1:0] r_bank;
    logic                   w_row_last;

    assign w_row_last   = (r_row == LOG_N_ROWS'(N_ROWS - 1));
    assign o_col_last   = (r_col == LOG_N_COLS'(N_COLS - 1));
    assign o_frame_last = w_row_last && (r_bank == LOG_N_BANKS'(N_BANKS - 1));
    assign o_col        = r_col;
    assign o_row        = r_row;
    assign o_bank       = r_bank;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_bank <= '0;
        end else if (i_clear) begin
            r_col  <= '0;
            r_row  <= '0;
            r_bank <= '0;
        end else begin
            if (i_col_inc)
                r_col <= r_col + 1'b1;
            if (i_row_inc) begin
                r_row <= r_row + 1'b1;
                if (w_row_last)
                    r_bank <= r_bank + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hub75_fb_writer.sv
// HUB75 frame-buffer write sequencer: streams raster pixels into the line buffer, stores
// each row, then swaps frame halves. Option: HUB75_FBW_VSYNC_EN gates the swap on swap_ok.
module hub75_fb_writer
    import hub75_fb_writer_pkg::*;
#(
    parameter int N_BANKS     = DEF_N_BANKS,
    parameter int N_ROWS      = DEF_N_ROWS,
    parameter int N_COLS      = DEF_N_COLS,
    parameter int N_CHANS     = DEF_N_CHANS,
    parameter int N_PLANES    = DEF_N_PLANES,
    parameter int LOG_N_BANKS = $clog2(N_BANKS),
    parameter int LOG_N_ROWS  = $clog2(N_ROWS),
    parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef HUB75_FBW_VSYNC_EN
    input  logic                          swap_ok,
`endif
    input  logic [N_CHANS*N_PLANES-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [LOG_N_BANKS-1:0]        wr_bank_addr,
    output logic [LOG_N_ROWS-1:0]         wr_row_addr,
    output logic                          wr_row_store,
    input  logic                          wr_row_rdy,
    output logic                          wr_row_swap,
    output logic [N_CHANS*N_PLANES-1:0]   wr_data,
    output logic [LOG_N_COLS-1:0]         wr_col_addr,
    output logic                          wr_en,
    output logic                          frame_swap,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int PIXEL_W = N_CHANS * N_PLANES;

    state_t                 r_state, w_next;
    logic                   r_hold;
    logic                   r_wr_en;
    logic [PIXEL_W-1:0]     r_wr_data;
    logic [LOG_N_COLS-1:0]  r_wr_col;
    logic [LOG_N_BANKS-1:0] r_bank_addr;
    logic [LOG_N_ROWS-1:0]  r_row_addr;
    logic                   w_accept, w_row_inc, w_clear, w_swap_ok;
    logic                   w_col_last, w_frame_last;
    logic [LOG_N_COLS-1:0]  w_col;
    logic [LOG_N_ROWS-1:0]  w_row;
    logic [LOG_N_BANKS-1:0] w_bank;

    hub75_fb_writer_addr_cnt #(
        .N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
        .LOG_N_BANKS(LOG_N_BANKS), .LOG_N_ROWS(LOG_N_ROWS), .LOG_N_COLS(LOG_N_COLS)
    ) u_addr_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_col_inc    (w_accept),
        .i_row_inc    (w_row_inc),
        .o_col        (w_col),
        .o_row        (w_row),
        .o_bank       (w_bank),
        .o_col_last   (w_col_last),
        .o_frame_last (w_frame_last)
    );

    // in_ready is gated by rst directly so the source never sees a handshake during reset.
    assign in_ready = (r_state == ST_FILL) && !rst;
    assign w_accept = in_valid && in_ready;

`ifdef HUB75_FBW_VSYNC_EN
    logic r_swap_seen;

    // Sticky from the last store cycle onward; a pulse during fill belongs to an earlier frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_swap_seen <= 1'b0;
        else if (r_state == ST_SWAP)
            r_swap_seen <= 1'b0;
        else if (swap_ok && (r_state == ST_WAIT_FRM || (r_state == ST_STORE && w_frame_last)))
            r_swap_seen <= 1'b1;
    end

    assign w_swap_ok = r_swap_seen || (swap_ok && r_state == ST_WAIT_FRM);
`else
    assign w_swap_ok = 1'b1;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next    = r_state;
        w_row_inc = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            ST_FILL:     if (w_accept && w_col_last) w_next = ST_WAIT_ROW;
            ST_WAIT_ROW: if (wr_row_rdy && !r_hold && !r_wr_en) w_next = ST_STORE;
            ST_STORE: begin
                w_row_inc = 1'b1;
                w_next    = w_frame_last ? ST_WAIT_FRM : ST_FILL;
            end
            ST_WAIT_FRM: if (wr_row_rdy && !r_hold && w_swap_ok) w_next = ST_SWAP;
            ST_SWAP: begin
                w_clear = 1'b1;
                w_next  = ST_FILL;
            end
            default:     w_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_hold      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_wr_col    <= '0;
            r_bank_addr <= '0;
            r_row_addr  <= '0;
        end else begin
            r_state <= w_next;
            // The frame buffer's pending flag lags our store pulse by one cycle.
            r_hold  <= (r_state == ST_STORE);
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_data <= in_data;
                r_wr_col  <= w_col;
            end
            if (r_state == ST_WAIT_ROW && w_next == ST_STORE) begin
                r_bank_addr <= w_bank;
                r_row_addr  <= w_row;
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_data      = r_wr_data;
    assign wr_col_addr  = r_wr_col;
    assign wr_bank_addr = r_bank_addr;
    assign wr_row_addr  = r_row_addr;
    assign wr_row_store = (r_state == ST_STORE);
    assign wr_row_swap  = (r_state == ST_STORE);
    assign frame_swap   = (r_state == ST_SWAP);
    assign frame_done   = (r_state == ST_SWAP);
    assign busy         = !(r_state == ST_FILL && w_col == '0 && w_row == '0 && w_bank == '0);

endmodule
